ha_serial_incr_ctrl: RTL and testbench
======================================

Name: ha_serial_incr_ctrl

Overview:
- Controller that time-shares a single half-adder cell to increment a WIDTH-bit counter register bit-serially, one bit per clock, LSB first.
- Requesters issue increment requests over a valid/ready handshake. A parallel load port presets the count.
- Sits above the 4-bit counter datapath: it trades the ripple chain of WIDTH half adders for one cell plus sequencing.
- Reports completion, wrap-around and saturation events as one-cycle pulses.

Parameters:
- WIDTH, 4, counter width in bits (≥2).
- WRAP_EN, 1, 1 = all-ones wraps to zero; 0 = saturate at all-ones.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- inc_req  in  1  increment request (valid).
- inc_ready  out  1  controller can accept an increment; combinational = (state==IDLE) && !load.
- load  in  1  parallel load strobe, sampled in IDLE only.
- load_val  in  WIDTH  value written on load.
- count  out  WIDTH  committed counter value (registered).
- busy  out  1  high while in ADD.
- done  out  1  one-cycle pulse: increment committed, count shows new value.
- wrap  out  1  one-cycle pulse with done when the final carry out = 1.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State IDLE; count, work register, carry, bit index, done and wrap all cleared.
  - busy=0; inc_ready=1 once rst_n=1 and load=0.
  - Reset mid-ADD discards the partial result; count reads 0.
- States: IDLE, ADD.
- IDLE, with priority load over inc_req:
  - load=1: count<=load_val next edge; no done or wrap; stay IDLE. inc_ready=0 this cycle, so no increment is accepted.
  - inc_req && inc_ready: work<=count, carry<=1, idx<=0, go ADD.
  - Otherwise hold.
- ADD (WIDTH cycles, idx = 0..WIDTH-1):
  - Half-adder inputs: a=work[idx], b=carry.
  - Each edge: work[idx]<=s, carry<=c, idx<=idx+1.
  - Exit on the edge where idx==WIDTH-1:
    - WRAP_EN=1: count<=result.
    - WRAP_EN=0 and final c=1: count unchanged (saturated at all-ones).
    - done<=1; wrap<=final c; state<=IDLE.
- Latency: request accepted at cycle T; done=1 and new count visible in cycle T+WIDTH+1.
  - inc_ready is high again in that same cycle, so back-to-back requests give one increment per WIDTH+1 cycles.
- count is stable (old value) throughout ADD; only the internal work register changes.
- Ignored while busy:
  - load is dropped (not queued).
  - inc_req is not acknowledged; the requester holds inc_req until inc_ready.
- done and wrap are registered. Each is high for exactly one cycle per completed increment and never otherwise.
- Wrap case, WIDTH=4, count=4'hF: result 4'h0, wrap=1 (WRAP_EN=1). With WRAP_EN=0: count stays 4'hF, wrap=1 (saturation indication).
- idx width is $clog2(WIDTH); it is never compared beyond WIDTH-1.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_IDLE=0, ST_ADD=1.
  - Default width constant CNT_WIDTH=4.
- One sub-module, ha_cell: 1-bit half adder with s=a^b, c=a&b, instantiated once. The controller contains no other arithmetic.
- The idx increment is a plain counter, not routed through ha_cell.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, then release → count=0, busy=0, done=0, inc_ready=1.
2. Single increment: inc_req for 1 cycle at T with count=0 → busy high for cycles T+1..T+4; done=1, count=1, wrap=0 at T+5; count held at 0 during T+1..T+4.
3. Ripple and wrap: load 4'h7 → count=7. Increment → 8. Load 4'hF, increment:
   - WRAP_EN=1 → count=0, wrap=1 with done.
   - WRAP_EN=0 → count=F, wrap=1.
4. Back-to-back: inc_req held high for 16 increments from 0 → done pulses every 5 cycles; count steps 1..15 then 0; wrap only on the 16th.
5. Conflicts:
   - load=1 and inc_req=1 together in IDLE → count=load_val, inc_ready=0, no done.
   - load=1 pulsed mid-ADD → ignored; result = old+1.
6. Reset mid-operation: rst_n=0 during ADD idx=2 (from count=5) → next cycle count=0, state IDLE, no done or wrap pulse.

Source files
------------

// File: rtl/ha_serial_incr_ctrl_pkg.sv
// rtl/ha_serial_incr_ctrl_pkg.sv - shared constants for the bit-serial increment controller
package ha_serial_incr_ctrl_pkg;

    localparam int CNT_WIDTH = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADD  = 1'b1
    } state_t;

endpackage

// File: rtl/ha_serial_incr_ctrl_ha_cell.sv
// rtl/ha_serial_incr_ctrl_ha_cell.sv - single 1-bit half adder shared across all counter bits
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/ha_serial_incr_ctrl.sv
// rtl/ha_serial_incr_ctrl.sv - increments a WIDTH-bit count one bit per clock through one half adder
module ha_serial_incr_ctrl
    import ha_serial_incr_ctrl_pkg::*;
#(
    parameter int WIDTH   = CNT_WIDTH,
    parameter bit WRAP_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_req,
    output logic             inc_ready,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] work_q,  work_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             done_q,  done_d;
    logic             wrap_q,  wrap_d;

    logic ha_a;
    logic ha_s;
    logic ha_c;

    assign ha_a = work_q[idx_q];

    ha_cell u_ha_cell (
        .a (ha_a),
        .b (carry_q),
        .s (ha_s),
        .c (ha_c)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        work_d  = work_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    count_d = load_val;
                end else if (inc_req) begin
                    work_d  = count_q;
                    carry_d = 1'b1;
                    idx_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                work_d[idx_q] = ha_s;
                carry_d       = ha_c;
                idx_d         = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    // Saturating build keeps all-ones when the final carry escapes.
                    if (WRAP_EN || !ha_c) begin
                        count_d = work_d;
                    end
                    idx_d   = '0;
                    done_d  = 1'b1;
                    wrap_d  = ha_c;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign inc_ready = (state_q == ST_IDLE) && !load;
    assign count     = count_q;
    assign busy      = (state_q == ST_ADD);
    assign done      = done_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_ha_serial_incr_ctrl.sv
// tb/tb_ha_serial_incr_ctrl.sv - wrapping and saturating controllers checked against a countdown model
module tb_ha_serial_incr_ctrl;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         inc_req = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;

    logic         rdy_w, rdy_s, busy_w, busy_s, done_w, done_s, wrap_w, wrap_s;
    logic [W-1:0] count_w, count_s;

    int n_cmp = 0;
    int n_bad = 0;

    int m_cw = 0, m_cs = 0, m_left = 0;
    bit m_done = 0, m_ww = 0, m_ws = 0, m_valid = 0;

    always #5 clk = ~clk;

    ha_serial_incr_ctrl #(.WIDTH(W), .WRAP_EN(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n), .inc_req(inc_req), .inc_ready(rdy_w),
        .load(load), .load_val(load_val), .count(count_w),
        .busy(busy_w), .done(done_w), .wrap(wrap_w)
    );

    ha_serial_incr_ctrl #(.WIDTH(W), .WRAP_EN(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n), .inc_req(inc_req), .inc_ready(rdy_s),
        .load(load), .load_val(load_val), .count(count_s),
        .busy(busy_s), .done(done_s), .wrap(wrap_s)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted increment occupies W cycles, then commits count+1.
    always @(posedge clk) begin
        m_done <= 1'b0;
        m_ww   <= 1'b0;
        m_ws   <= 1'b0;
        if (!rst_n) begin
            m_cw    <= 0;
            m_cs    <= 0;
            m_left  <= 0;
            m_valid <= 1'b1;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_cw   <= (m_cw + 1) % (MAX + 1);
                m_cs   <= (m_cs == MAX) ? MAX : m_cs + 1;
                m_ww   <= (m_cw == MAX);
                m_ws   <= (m_cs == MAX);
            end
        end else if (load) begin
            m_cw <= int'(load_val);
            m_cs <= int'(load_val);
        end else if (inc_req) begin
            m_left <= W;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_count_w", int'(count_w), m_cw);
            chk("model_count_s", int'(count_s), m_cs);
            chk("model_busy_w", int'(busy_w), int'(m_left > 0));
            chk("model_busy_s", int'(busy_s), int'(m_left > 0));
            chk("model_done_w", int'(done_w), int'(m_done));
            chk("model_done_s", int'(done_s), int'(m_done));
            chk("model_wrap_w", int'(wrap_w), int'(m_ww));
            chk("model_wrap_s", int'(wrap_s), int'(m_ws));
            chk("model_ready_w", int'(rdy_w), int'((m_left == 0) && !load));
            chk("model_ready_s", int'(rdy_s), int'((m_left == 0) && !load));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit req, input bit ld, input int val);
        inc_req  = req;
        load     = ld;
        load_val = W'(val);
    endtask

    task automatic do_inc();
        drive(1, 0, 0);
        tick();
        drive(0, 0, 0);
        repeat (4) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_count", int'(count_w), 0);
        chk("reset_busy", int'(busy_w), 0);
        chk("reset_done", int'(done_w), 0);
        chk("reset_ready", int'(rdy_w), 1);

        tick();
        drive(1, 0, 0);
        tick();
        drive(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("single_busy", int'(busy_w), 1);
            chk("single_count_held", int'(count_w), 0);
            tick();
        end
        @(negedge clk);
        chk("single_done", int'(done_w), 1);
        chk("single_count", int'(count_w), 1);
        chk("single_wrap", int'(wrap_w), 0);

        tick();
        drive(0, 1, 7);
        tick();
        drive(0, 0, 0);
        @(negedge clk);
        chk("load7_count", int'(count_w), 7);
        tick();
        do_inc();
        @(negedge clk);
        chk("ripple_count", int'(count_w), 8);
        chk("ripple_wrap", int'(wrap_w), 0);

        tick();
        drive(0, 1, 15);
        tick();
        drive(0, 0, 0);
        do_inc();
        @(negedge clk);
        chk("wrap_count_w", int'(count_w), 0);
        chk("wrap_flag_w", int'(wrap_w), 1);
        chk("sat_count_s", int'(count_s), 15);
        chk("sat_flag_s", int'(wrap_s), 1);
        chk("wrap_done", int'(done_w), 1);

        tick();
        drive(0, 1, 0);
        tick();
        drive(1, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            repeat (5) tick();
            @(negedge clk);
            chk("b2b_done", int'(done_w), 1);
            chk("b2b_count", int'(count_w), k % 16);
            chk("b2b_wrap", int'(wrap_w), int'(k == 16));
        end
        tick();
        drive(0, 0, 0);
        repeat (6) tick();

        drive(1, 1, 9);
        @(negedge clk);
        chk("conflict_ready", int'(rdy_w), 0);
        tick();
        drive(0, 0, 0);
        @(negedge clk);
        chk("conflict_count", int'(count_w), 9);
        chk("conflict_busy", int'(busy_w), 0);
        chk("conflict_done", int'(done_w), 0);
        tick();
        drive(1, 0, 0);
        tick();
        drive(0, 1, 3);
        tick();
        drive(0, 0, 0);
        repeat (3) tick();
        @(negedge clk);
        chk("midload_count", int'(count_w), 10);
        chk("midload_done", int'(done_w), 1);

        tick();
        drive(0, 1, 5);
        tick();
        drive(1, 0, 0);
        tick();
        drive(0, 0, 0);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_count", int'(count_w), 0);
        chk("midrst_busy", int'(busy_w), 0);
        chk("midrst_done", int'(done_w), 0);
        repeat (5) begin
            tick();
            @(negedge clk);
            chk("midrst_no_done", int'(done_w), 0);
            chk("midrst_no_wrap", int'(wrap_w), 0);
        end

        for (int c = 0; c < 600; c++) begin
            tick();
            inc_req  = ($urandom_range(0, 99) < 60);
            load     = ($urandom_range(0, 99) < 12);
            load_val = W'($urandom_range(0, MAX));
            rst_n    = ($urandom_range(0, 199) != 0);
        end
        tick();
        rst_n = 1'b1;
        drive(0, 0, 0);
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
